// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter (8N1) with a small byte FIFO in front of it.
// Sends status/telemetry bytes back to the host over the serial link.
//
// Build option: define TX_PARITY_EN to add an even-parity bit between the
// last data bit and the stop bit (frame becomes 11 bit periods).
//
// Parameters:
//   CLKRATE    oscillator frequency in Hz
//   BAUDRATE   serial bit rate; bit period DIV = CLKRATE/BAUDRATE (>= 2)
//   FIFO_DEPTH byte entries, power of 2, >= 2
//
// Ports:
//   osc        system clock, rising edge
//   rst        synchronous reset, active-high
//   tx_data    byte offered to the FIFO
//   tx_valid   producer offers tx_data this cycle
//   tx_ready   FIFO not full
//   tx         serial line, idle high, registered
//   busy       frame on the line or FIFO non-empty, registered
//   fifo_count bytes queued, excluding the byte being shifted
module uart_tx_fifo #(
   parameter int CLKRATE    = 12_000_000,
   parameter int BAUDRATE   = 9600,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          osc,
   input  logic                          rst,
   input  logic [7:0]                    tx_data,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int DIV = CLKRATE / BAUDRATE;
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int CW  = AW + 1;
   localparam int BW  = (DIV > 2) ? $clog2(DIV) : 1;

   if (DIV < 2) begin : g_bad_div
      $error("uart_tx_fifo: CLKRATE/BAUDRATE must be at least 2");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2 and at least 2");
   end

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_STOP   = 3'd4;
`ifdef TX_PARITY_EN
   localparam logic [2:0] ST_PARITY = 3'd3;
`endif

   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [CW-1:0] count_q, count_d;
   logic [2:0]    state_q, state_d;
   logic [BW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;
   logic          busy_q, busy_d;
   logic          push, pop, cnt_last;
`ifdef TX_PARITY_EN
   logic          par_q, par_d;
`endif

   assign tx_ready   = (count_q != CW'(FIFO_DEPTH));
   assign push       = tx_valid && tx_ready;
   assign cnt_last   = (cnt_q == BW'(DIV - 1));
   assign tx         = tx_q;
   assign busy       = busy_q;
   assign fifo_count = count_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + BW'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
      pop     = 1'b0;
`ifdef TX_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (count_q != '0) begin
               pop     = 1'b1;
               state_d = ST_START;
               shift_d = mem_q[rd_q];
`ifdef TX_PARITY_EN
               par_d   = ^mem_q[rd_q];
`endif
            end
         end
         ST_START: begin
            if (cnt_last) begin
               state_d = ST_DATA;
               cnt_d   = '0;
               bit_d   = '0;
            end
         end
         ST_DATA: begin
            if (cnt_last) begin
               cnt_d   = '0;
               shift_d = {1'b0, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
`ifdef TX_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end
            end
         end
`ifdef TX_PARITY_EN
         ST_PARITY: begin
            if (cnt_last) begin
               state_d = ST_STOP;
               cnt_d   = '0;
            end
         end
`endif
         ST_STOP: begin
            if (cnt_last) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Line level follows the state held before the edge, so tx trails the FSM
   // by one clock (pop at N+1, start bit visible from N+2).
   always_comb begin
      case (state_q)
         ST_START:  tx_d = 1'b0;
         ST_DATA:   tx_d = shift_q[0];
`ifdef TX_PARITY_EN
         ST_PARITY: tx_d = par_q;
`endif
         default:   tx_d = 1'b1;
      endcase
   end

   always_comb begin
      count_d = count_q;
      if (push && !pop)
         count_d = count_q + CW'(1);
      else if (pop && !push)
         count_d = count_q - CW'(1);
   end

   assign busy_d = (state_q != ST_IDLE) || (count_q != '0);

   always_ff @(posedge osc) begin
      if (push)
         mem_q[wr_q] <= tx_data;
   end

   always_ff @(posedge osc) begin
      if (rst) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
`ifdef TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         if (push)
            wr_q <= wr_q + AW'(1);
         if (pop)
            rd_q <= rd_q + AW'(1);
         count_q <= count_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
`ifdef TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: checks uart_tx_fifo against a queue/timeline model of the
// serial frame, plus a run of the default-rate configuration.
module tb_uart_tx_fifo;

   localparam int DIV   = 16;
   localparam int DEPTH = 4;
   localparam int DDIV  = 1250;
`ifdef TX_PARITY_EN
   localparam int NB    = 11;
`else
   localparam int NB    = 10;
`endif

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready, tx, busy;
   logic [2:0] fifo_count;

   logic       d_rst, d_valid;
   logic [7:0] d_data;
   logic       d_ready, d_tx, d_busy;
   logic [2:0] d_count;

   uart_tx_fifo #(.CLKRATE(16), .BAUDRATE(1), .FIFO_DEPTH(DEPTH)) u_dut (
      .osc(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .tx(tx), .busy(busy), .fifo_count(fifo_count)
   );

   uart_tx_fifo u_def (
      .osc(clk), .rst(d_rst), .tx_data(d_data), .tx_valid(d_valid),
      .tx_ready(d_ready), .tx(d_tx), .busy(d_busy), .fifo_count(d_count)
   );

   int tests = 0;
   int fails = 0;

   // Model: queue of pending bytes plus the edge count since the current
   // byte was popped (-1 when no frame is in progress).
   int         mq[$];
   int         m_t = -1;
   logic [7:0] m_cur = '0;
   logic       m_tx = 1'b1;
   logic       m_busy = 1'b0;

   function automatic logic frame_bit(input logic [7:0] b, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return b[idx-1];
      if (NB == 11 && idx == 9) return ^b;
      return 1'b1;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      logic act;
      int   cnt;
      logic rdy;
      act = (m_t >= 0);
      cnt = mq.size();
      rdy = (cnt < DEPTH);
      if (rst) begin
         mq.delete();
         m_t    = -1;
         m_tx   = 1'b1;
         m_busy = 1'b0;
         return;
      end
      m_busy = act || (cnt != 0);
      m_tx   = 1'b1;
      if (act) begin
         m_t++;
         m_tx = frame_bit(m_cur, (m_t - 1) / DIV);
         if (m_t == NB * DIV) m_t = -1;
      end else if (cnt > 0) begin
         m_cur = 8'(mq.pop_front());
         m_t   = 0;
      end
      if (tx_valid && rdy) mq.push_back(int'(tx_data));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check("tx", 32'(tx), 32'(m_tx));
      check("busy", 32'(busy), 32'(m_busy));
      check("fifo_count", 32'(fifo_count), 32'(mq.size()));
      check("tx_ready", 32'(tx_ready), 32'(mq.size() < DEPTH));
   endtask

   task automatic wait_idle(input int limit);
      int done;
      done = 0;
      for (int i = 0; i < limit; i++) begin
         if (m_t < 0 && mq.size() == 0) begin
            done = 1;
            break;
         end
         step();
      end
      check("wait_idle", 32'(done), 32'd1);
   endtask

   initial begin
      int n;
      int lows;
      rst = 1'b1; tx_valid = 1'b0; tx_data = '0;
      d_rst = 1'b1; d_valid = 1'b0; d_data = '0;

      // reset
      step(); step();
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ready", 32'(tx_ready), 32'd1);
      check("rst_count", 32'(fifo_count), 32'd0);
      rst = 1'b0;
      step(); step();

      // single byte 0x55; start bit appears two edges after the push
      tx_valid = 1'b1; tx_data = 8'h55;
      step();
      tx_valid = 1'b0;
      n = 0;
      while (tx !== 1'b0 && n < 10) begin step(); n++; end
      check("latency", 32'(n), 32'd2);
      wait_idle(NB * DIV + 20);
      step(); step();

      // fill the FIFO past capacity
      for (int b = 1; b <= 5; b++) begin
         tx_valid = 1'b1; tx_data = 8'(b);
         step();
      end
      check("full_count", 32'(fifo_count), 32'd4);
      tx_data = 8'h06;
      check("full_ready", 32'(tx_ready), 32'd0);
      step();
      tx_valid = 1'b0;
      check("full_reject", 32'(fifo_count), 32'd4);
      wait_idle(6 * (NB * DIV + 1) + 20);

      // push on the same edge as the pop of the last queued byte
      tx_valid = 1'b1; tx_data = 8'h3C; step();
      tx_data = 8'hC3; step();
      tx_valid = 1'b0;
      n = 0;
      while (!(m_t < 0 && mq.size() == 1) && n < NB * DIV + 20) begin step(); n++; end
      check("sim_reach", 32'(m_t < 0 && mq.size() == 1), 32'd1);
      tx_valid = 1'b1; tx_data = 8'h81;
      step();
      tx_valid = 1'b0;
      check("sim_count", 32'(fifo_count), 32'd1);
      wait_idle(3 * (NB * DIV + 1) + 20);

      // random traffic
      for (int i = 0; i < 1500; i++) begin
         tx_valid = ($urandom_range(0, 99) < 8);
         tx_data  = 8'($urandom);
         step();
      end
      tx_valid = 1'b0;
      wait_idle((DEPTH + 1) * (NB * DIV + 1) + 20);

      // reset during data bit 3 of 0xA5 with two bytes queued
      tx_valid = 1'b1; tx_data = 8'hA5; step();
      tx_data = 8'h11; step();
      tx_data = 8'h22; step();
      tx_valid = 1'b0;
      n = 0;
      while (m_t != 4 * DIV + 8 && n < NB * DIV) begin step(); n++; end
      check("mid_reach", 32'(m_t), 32'(4 * DIV + 8));
      check("mid_queued", 32'(fifo_count), 32'd2);
      rst = 1'b1;
      step();
      check("mid_tx", 32'(tx), 32'd1);
      check("mid_count", 32'(fifo_count), 32'd0);
      check("mid_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      lows = 0;
      for (int i = 0; i < 3 * NB * DIV; i++) begin
         step();
         if (tx === 1'b0) lows++;
      end
      check("mid_silent", 32'(lows), 32'd0);

      // default configuration, 0x00
      d_rst = 1'b0;
      @(posedge clk); #1;
      d_valid = 1'b1; d_data = 8'h00;
      @(posedge clk); #1;
      d_valid = 1'b0;
      n = 0;
      while (d_tx !== 1'b0 && n < 10) begin @(posedge clk); #1; n++; end
      check("def_latency", 32'(n), 32'd2);
      n = 0;
      while (d_tx === 1'b0 && n < 20 * DDIV) begin @(posedge clk); #1; n++; end
      check("def_low", 32'(n), 32'((NB - 1) * DDIV));
      n = 0;
      while (d_busy === 1'b1 && n < 4 * DDIV) begin @(posedge clk); #1; n++; end
      check("def_stop", 32'(n), 32'(DDIV));
      check("def_tx_idle", 32'(d_tx), 32'd1);
      check("def_count", 32'(d_count), 32'd0);
      check("def_ready", 32'(d_ready), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
